// File: rtl/piso_frame_tx_if.sv
// rtl/piso_frame_tx_if.sv - parallel load handshake between a word producer and piso_frame_tx
interface piso_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output din,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  din,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/piso_frame_tx.sv
// rtl/piso_frame_tx.sv - PISO frame transmitter: start, WIDTH data bits LSB-first, stop
// Optional even-parity bit before stop when PISO_PARITY_EN is defined.
module piso_frame_tx #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 inz,
    piso_frame_tx_if.slave       load,
    output logic                 sout,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;
    logic             sout_q;
    logic             busy_q;
    logic             done_q;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif
    logic             accept;

    assign load.load_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept          = load.load_valid && load.load_ready;

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

    // Outputs are registered with the state, so sout always shows the bit of the current state.
    always_ff @(posedge clk) begin
        if (inz) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            sout_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (accept) begin
            state_q  <= START;
            shift_q  <= load.din;
            sout_q   <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= ^load.din;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    sout_q <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                START: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    sout_q  <= shift_q[0];
                    shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                end
                DATA: begin
                    if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
                        state_q <= PARITY;
                        sout_q  <= parity_q;
`else
                        state_q <= STOP;
                        sout_q  <= 1'b1;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        sout_q  <= shift_q[0];
                        shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_q <= STOP;
                    sout_q  <= 1'b1;
                    done_q  <= 1'b1;
                end
`endif
                STOP: begin
                    state_q <= IDLE;
                    sout_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sout_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_frame_tx.sv
// tb/tb_piso_frame_tx.sv - scoreboard bench for piso_frame_tx (WIDTH=8), parity-aware via PISO_PARITY_EN
module tb_piso_frame_tx;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic s;
        logic b;
        logic d;
    } ent_t;

    logic clk;
    logic inz;
    logic sout;
    logic busy;
    logic done;

    piso_frame_tx_if #(.WIDTH(WIDTH)) lif ();

    piso_frame_tx #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .inz  (inz),
        .load (lif),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string tag, input string what, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s %s observed=%b expected=%b", tag, what, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d);
        exp_q.push_back('{s: 1'b0, b: 1'b1, d: 1'b0});
        for (int i = 0; i < WIDTH; i++)
            exp_q.push_back('{s: d[i], b: 1'b1, d: 1'b0});
`ifdef PISO_PARITY_EN
        exp_q.push_back('{s: ^d, b: 1'b1, d: 1'b0});
`endif
        exp_q.push_back('{s: 1'b1, b: 1'b1, d: 1'b1});
    endtask

    task automatic check(input string tag);
        ent_t e;
        logic rdy;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{s: 1'b1, b: 1'b0, d: 1'b0};
        rdy = (exp_q.size() == 0);
        cmp(tag, "sout", sout, e.s);
        cmp(tag, "busy", busy, e.b);
        cmp(tag, "done", done, e.d);
        cmp(tag, "load_ready", lif.load_ready, rdy);
    endtask

    // Called at a falling edge: drive inputs, update the model, clock once, check the new cycle.
    task automatic step(input logic i, input logic lv, input logic [WIDTH-1:0] d,
                        input string tag, output logic acc);
        inz            = i;
        lif.load_valid = lv;
        lif.din        = d;
        acc = lv && !i && (exp_q.size() == 0);
        if (i) exp_q.delete();
        else if (acc) push_frame(d);
        @(posedge clk);
        @(negedge clk);
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        logic a;
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, '0, tag, a);
    endtask

    initial begin
        logic a;
        int   nacc;
        inz            = 1'b1;
        lif.load_valid = 1'b1;
        lif.din        = 8'hFF;

        step(1'b1, 1'b1, 8'hFF, "reset0", a);
        step(1'b1, 1'b1, 8'hFF, "reset1", a);
        idle(3, "post_reset");

        step(1'b0, 1'b1, 8'hA5, "a5_accept", a);
        cmp("a5_accept", "accepted", a, 1'b1);
        idle(13, "a5_frame");

        step(1'b0, 1'b1, 8'h01, "x01_accept", a);
        idle(13, "x01_frame");

        nacc = 0;
        for (int c = 0; c < 40 && nacc < 2; c++) begin
            step(1'b0, 1'b1, (nacc == 0) ? 8'h3C : 8'hC3, "b2b", a);
            if (a) nacc++;
        end
        cmp("b2b", "two_accepts", (nacc == 2), 1'b1);
        idle(13, "b2b_drain");

        step(1'b0, 1'b1, 8'h96, "stall_accept", a);
        idle(1, "stall_start");
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 8'h00, "stall_pulse", a);
        idle(10, "stall_drain");

        step(1'b0, 1'b1, 8'hFF, "abort_accept", a);
        idle(4, "abort_data");
        step(1'b1, 1'b1, 8'hAA, "abort_inz", a);
        cmp("abort_inz", "accepted", a, 1'b0);
        idle(1, "abort_idle");
        step(1'b0, 1'b1, 8'h0F, "fresh_accept", a);
        idle(13, "fresh_frame");

        nacc = 0;
        for (int c = 0; c < 80 && nacc < 4; c++) begin
            step(1'b0, 1'b1, WIDTH'($urandom_range(0, 255)), "rand_b2b", a);
            if (a) nacc++;
        end
        idle(13, "rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
